mem_access_unit: RTL and testbench

- Memory-side stage directly downstream of the multi-cycle Controller.
- Turns the Controller's MemRead/MemWrite/IRWrite/IorD-selected address into a req/ack transaction with a variable-latency memory.
- Holds the Instruction Register and Memory Data Register, and raises Stall so the Controller freezes its state until the access completes.
- Detects misaligned addresses and memory timeouts.

---
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-side stage sitting directly after the multi-cycle Controller. It
// turns a MemRead/MemWrite pulse into a req/ack transaction with a
// variable-latency memory. It also holds the Instruction Register and the
// Memory Data Register, and raises Stall so the Controller holds its state
// until the access completes.
//
// Handshake: the unit raises mem_req and holds mem_addr, mem_we and mem_wdata
// stable until memory answers. Memory answers with a single-cycle mem_ack,
// and mem_rdata is valid in that same cycle. mem_ack is ignored in every
// state except REQ.
//
// Parameter:
//   TIMEOUT   - REQ cycles allowed without mem_ack before the access is
//               aborted (1..255).
//
// Optional feature (macro MEM_PERF_CNT_EN):
//   Defined   - AccessCnt counts completed accesses and WaitCnt counts REQ
//               cycles without ack. Both counters saturate.
//   Undefined - both counters are tied to 0.
//
// Ports:
//   clk, reset            - rising-edge clock; synchronous active-low reset
//   MemRead, MemWrite     - Controller commands; a rising edge of their OR is
//                           one command
//   IRWrite               - together with MemRead, marks an instruction fetch
//   Address, WriteData    - byte address and store data, latched on accept
//   mem_req, mem_we       - memory request and write enable
//   mem_addr, mem_wdata   - registered address and write data
//   mem_rdata, mem_ack    - memory read data and completion strobe
//   Instruction, MemData  - IR and MDR contents
//   Stall                 - Controller must hold its state while 1
//   Done                  - one-cycle completion pulse (success or error)
//   AccessErr             - sticky error flag for misalignment, read+write
//                           together, or timeout
//   AccessCnt, WaitCnt    - performance counters
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        IRWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] Instruction,
   output logic [31:0] MemData,
   output logic        Stall,
   output logic        Done,
   output logic        AccessErr,
   output logic [31:0] AccessCnt,
   output logic [31:0] WaitCnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic       cmd;
   logic       cmd_prev;
   logic       accept;
   logic       bad_cmd;
   logic       is_fetch;
   logic [7:0] wait_cnt;

   // Edge detection on the command: a command held high is issued only once.
   assign cmd     = MemRead | MemWrite;
   assign accept  = (state == IDLE) & cmd & ~cmd_prev;
   assign bad_cmd = (MemRead & MemWrite) | (Address[1:0] != 2'b00);

   // Stall is combinational so that the Controller freezes in the same cycle
   // it issues the command.
   assign Stall = (state == REQ) | accept;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         cmd_prev    <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         Instruction <= '0;
         MemData     <= '0;
         Done        <= 1'b0;
         AccessErr   <= 1'b0;
         is_fetch    <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         cmd_prev <= cmd;
         Done     <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bad_cmd) begin
                     // A rejected command never reaches memory.
                     AccessErr <= 1'b1;
                     Done      <= 1'b1;
                     state     <= ERR;
                  end else begin
                     mem_addr  <= Address;
                     mem_wdata <= WriteData;
                     mem_we    <= MemWrite;
                     is_fetch  <= IRWrite & MemRead;
                     wait_cnt  <= '0;
                     mem_req   <= 1'b1;
                     state     <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  if (!mem_we) begin
                     if (is_fetch) Instruction <= mem_rdata;
                     else          MemData     <= mem_rdata;
                  end
                  mem_req <= 1'b0;
                  Done    <= 1'b1;
                  state   <= DONE;
               end else if (wait_cnt == WAIT_LAST) begin
                  mem_req   <= 1'b0;
                  Done      <= 1'b1;
                  AccessErr <= 1'b1;
                  state     <= ERR;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         AccessCnt <= '0;
         WaitCnt   <= '0;
      end else begin
         // DONE is entered exactly when an ack arrives in REQ.
         if ((state == REQ) && mem_ack && (AccessCnt != 32'hFFFF_FFFF))
            AccessCnt <= AccessCnt + 32'd1;
         if ((state == REQ) && !mem_ack && (WaitCnt != 32'hFFFF_FFFF))
            WaitCnt <= WaitCnt + 32'd1;
      end
   end
`else
   assign AccessCnt = '0;
   assign WaitCnt   = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Transaction-level bench for mem_access_unit. Each access is described by
// its command, its address and data, and the number of ack wait cycles. From
// that description the driver task derives the cycle-by-cycle expectations:
// when Stall, mem_req and Done are high, which register changes, and how the
// counters move. A negedge compare process checks every DUT output against
// these expectations. Directed cases pin the expectations with literal
// values; a randomized loop follows them.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite, IRWrite;
   logic [31:0] Address, WriteData;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] Instruction, MemData;
   logic        Stall, Done, AccessErr;
   logic [31:0] AccessCnt, WaitCnt;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .Address(Address), .WriteData(WriteData),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .Instruction(Instruction), .MemData(MemData),
      .Stall(Stall), .Done(Done), .AccessErr(AccessErr),
      .AccessCnt(AccessCnt), .WaitCnt(WaitCnt)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- expected values ----------------
   logic        m_req, m_we, m_stall, m_done, m_err;
   logic [31:0] m_addr, m_wdata, m_instr, m_mdr, m_acc, m_wait;
   bit          chk_en = 1'b0;

   int n_checks = 0;
   int n_err    = 0;
   int last_done = -1;
   int cmd_cyc   = 0;
   int stall_cnt = 0;
   int req_cnt   = 0;

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic m_reset();
      m_req = 0; m_we = 0; m_stall = 0; m_done = 0; m_err = 0;
      m_addr = 0; m_wdata = 0; m_instr = 0; m_mdr = 0; m_acc = 0; m_wait = 0;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("mem_req",     32'(mem_req),   32'(m_req));
         chk("mem_we",      32'(mem_we),    32'(m_we));
         chk("mem_addr",    mem_addr,       m_addr);
         chk("mem_wdata",   mem_wdata,      m_wdata);
         chk("Instruction", Instruction,    m_instr);
         chk("MemData",     MemData,        m_mdr);
         chk("Stall",       32'(Stall),     32'(m_stall));
         chk("Done",        32'(Done),      32'(m_done));
         chk("AccessErr",   32'(AccessErr), 32'(m_err));
`ifdef MEM_PERF_CNT_EN
         chk("AccessCnt",   AccessCnt,      m_acc);
         chk("WaitCnt",     WaitCnt,        m_wait);
`else
         chk("AccessCnt",   AccessCnt,      32'd0);
         chk("WaitCnt",     WaitCnt,        32'd0);
`endif
      end
      if (Done === 1'b1)    last_done = cyc;
      if (Stall === 1'b1)   stall_cnt++;
      if (mem_req === 1'b1) req_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_cmd();
      MemRead = 0; MemWrite = 0; IRWrite = 0;
   endtask

   // Scramble the inputs the DUT must not look at after the command cycle.
   task automatic scramble();
      Address   = $urandom;
      WriteData = $urandom;
   endtask

   // mem_ack is meaningless outside REQ, so drive it randomly there.
   task automatic noise();
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(); drop_cmd(); scramble(); noise();
         m_stall = 0; m_done = 0;
      end
   endtask

   // One access: rd/wr/irw command bits, the address and data, the number of
   // REQ cycles memory waits before it acks (waits >= TO means no ack), the
   // read data, and whether the command stays high past completion.
   task automatic access(input bit rd, input bit wr, input bit irw,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int waits, input logic [31:0] rdata, input bit hold);
      bit bad;
      bit acked;
      int nreq;
      bad   = (rd && wr) || (addr[1:0] != 2'b00);
      acked = (waits < TO);
      nreq  = acked ? waits + 1 : TO;

      step();
      MemRead = rd; MemWrite = wr; IRWrite = irw; Address = addr; WriteData = wd;
      noise();
      cmd_cyc = cyc;
      m_stall = 1; m_done = 0; m_req = 0;

      if (bad) begin
         step(); if (!hold) drop_cmd(); scramble(); noise();
         m_stall = 0; m_done = 1; m_err = 1;
      end else begin
         for (int j = 1; j <= nreq; j++) begin
            step(); if (!hold) drop_cmd(); scramble();
            mem_ack   = acked && (j == nreq);
            mem_rdata = mem_ack ? rdata : $urandom;
            if (j > 1) m_wait = sat(m_wait);
            m_req = 1; m_stall = 1; m_done = 0;
            m_addr = addr; m_wdata = wd; m_we = wr;
         end
         step(); if (!hold) drop_cmd(); scramble(); noise();
         m_req = 0; m_stall = 0; m_done = 1;
         if (acked) begin
            m_acc = sat(m_acc);
            if (rd) begin
               if (irw) m_instr = rdata;
               else     m_mdr   = rdata;
            end
         end else begin
            m_err  = 1;
            m_wait = sat(m_wait);
         end
      end

      for (int k = 0; k < (hold ? 4 : 0); k++) begin
         step(); scramble(); noise();
         m_stall = 0; m_done = 0;
      end
      step(); drop_cmd(); scramble(); noise();
      m_stall = 0; m_done = 0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] tmp;
      logic [31:0] addr;
      bit rd, wr, irw;
      int r;

      reset = 0; MemRead = 0; MemWrite = 0; IRWrite = 0;
      Address = 0; WriteData = 0; mem_rdata = 32'hFFFF_FFFF; mem_ack = 1;
      m_reset();

      // Reset held for two edges while memory asserts ack.
      step(); chk_en = 1;
      step(); reset = 1; mem_ack = 0;
      chk("reset_ir",  Instruction, 32'd0);
      chk("reset_req", 32'(mem_req), 32'd0);
      idle(2);

      // Fetch, acked on the first REQ cycle.
      stall_cnt = 0;
      access(1, 0, 1, 32'h0040_0000, 32'h0, 0, 32'h2008_0005, 0);
      chk("fetch_ir",      Instruction, 32'h2008_0005);
      chk("fetch_mdr",     MemData, 32'h0);
      chk("fetch_latency", 32'(last_done - cmd_cyc), 32'd2);
      chk("fetch_stall",   32'(stall_cnt), 32'd2);
      idle(1);

      // Load with three wait cycles.
      access(1, 0, 0, 32'h1001_0004, 32'h0, 3, 32'hDEAD_BEEF, 0);
      chk("load_mdr",     MemData, 32'hDEAD_BEEF);
      chk("load_ir",      Instruction, 32'h2008_0005);
      chk("load_latency", 32'(last_done - cmd_cyc), 32'd5);
`ifdef MEM_PERF_CNT_EN
      chk("load_waitcnt", WaitCnt, 32'd3);
`else
      chk("load_waitcnt", WaitCnt, 32'd0);
`endif
      idle(1);

      // Store with the command held four cycles past completion.
      req_cnt = 0;
      access(0, 1, 0, 32'h1001_0008, 32'h1234_5678, 1, 32'h5555_5555, 1);
      chk("store_ir",   Instruction, 32'h2008_0005);
      chk("store_mdr",  MemData, 32'hDEAD_BEEF);
      chk("store_reqs", 32'(req_cnt), 32'd2);
      idle(1);

      // Timeout: no ack at all.
      req_cnt = 0;
      access(1, 0, 0, 32'h1001_000C, 32'h0, TO, 32'h0, 0);
      chk("timeout_reqs",    32'(req_cnt), 32'd4);
      chk("timeout_latency", 32'(last_done - cmd_cyc), 32'd5);
      chk("timeout_err",     32'(AccessErr), 32'd1);
      idle(2);
      chk("err_sticky", 32'(AccessErr), 32'd1);

      // Misaligned address.
      req_cnt = 0;
      access(1, 0, 0, 32'h1001_0002, 32'h0, 0, 32'h0, 0);
      chk("misalign_reqs", 32'(req_cnt), 32'd0);
      chk("misalign_err",  32'(AccessErr), 32'd1);
      idle(1);

      // Reset during the second REQ cycle, then a late ack.
      step();
      MemRead = 1; MemWrite = 0; IRWrite = 0; Address = 32'h1001_0010;
      WriteData = 32'hA5A5_A5A5; mem_ack = 0;
      m_stall = 1; m_done = 0; m_req = 0;
      step(); drop_cmd(); mem_ack = 0;
      m_req = 1; m_stall = 1; m_addr = 32'h1001_0010; m_wdata = 32'hA5A5_A5A5; m_we = 0;
      step(); reset = 0; chk_en = 0;
      step(); reset = 1; chk_en = 1; m_reset();
      mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
      step(); mem_ack = 0;
      chk("rst_mid_req", 32'(mem_req), 32'd0);
      chk("rst_mid_mdr", MemData, 32'd0);
      chk("rst_mid_err", 32'(AccessErr), 32'd0);
      idle(2);

      // Randomized accesses.
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         tmp = $urandom;
         addr = {tmp[31:2], 2'b00};
         rd = 0; wr = 0; irw = 1'($urandom_range(0, 1));
         if (r < 4)       rd = 1;
         else if (r < 8)  wr = 1;
         else if (r == 8) begin rd = 1; wr = 1; end
         else begin
            rd = 1;
            addr = {tmp[31:2], 2'($urandom_range(1, 3))};
         end
         access(rd, wr, irw, addr, $urandom, $urandom_range(0, TO + 1),
                $urandom, ($urandom_range(0, 3) == 0));
         idle($urandom_range(0, 2));
      end

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
